// File: rtl/cpu_decode_pkg.sv
// cpu_decode_pkg: class bit layout, MIPS-I opcode/funct constants and the decode queue entry type
package cpu_decode_pkg;
    localparam int CLS_W            = 12;
    localparam int CLS_LOAD         = 0;
    localparam int CLS_STORE        = 1;
    localparam int CLS_ALU          = 2;
    localparam int CLS_SHIFT        = 3;
    localparam int CLS_MULMOVE      = 4;
    localparam int CLS_MULEXEC      = 5;
    localparam int CLS_BRANCH       = 6;
    localparam int CLS_CP0          = 7;
    localparam int CLS_EXC          = 8;
    localparam int CLS_HAS_IMM      = 9;
    localparam int CLS_COULD_BRANCH = 10;
    localparam int CLS_NOP          = 11;
    localparam logic [5:0] OP_SPECIAL = 6'o00;
    localparam logic [5:0] OP_REGIMM  = 6'o01;
    localparam logic [5:0] OP_J       = 6'o02;
    localparam logic [5:0] OP_JAL     = 6'o03;
    localparam logic [5:0] OP_COP0    = 6'o20;
    localparam logic [5:0] FN_JR      = 6'o10;
    localparam logic [5:0] FN_JALR    = 6'o11;
    localparam logic [5:0] FN_SYSCALL = 6'o14;
    localparam logic [5:0] FN_BREAK   = 6'o15;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;
    localparam logic [4:0] REG_RA     = 5'd31;
    typedef struct packed {
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic [CLS_W-1:0] cls;
        logic [4:0]       rr1;
        logic [4:0]       rr2;
        logic [4:0]       rw;
        logic             ds;
    } entry_t;
endpackage

// File: rtl/cpu_inst_classify.sv
// cpu_inst_classify: combinational MIPS-I classifier, inst -> class vector and register indices
// Ports: inst (in, 32); cls (out, CLS_W); rr1/rr2 (out, 5) source regs; rw (out, 5) destination, 0 = none
module cpu_inst_classify import cpu_decode_pkg::*; (
    input  logic [31:0]      inst,
    output logic [CLS_W-1:0] cls,
    output logic [4:0]       rr1,
    output logic [4:0]       rr2,
    output logic [4:0]       rw
);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic special, load, store, alu_imm, alu, shift, mulmove, mulexec;
    logic jump, bcond, branch, link, cp0, exc, has_imm;
    logic unused_shamt;
    assign op = inst[31:26];
    assign rs = inst[25:21];
    assign rt = inst[20:16];
    assign rd = inst[15:11];
    assign fn = inst[5:0];
    assign unused_shamt = ^inst[10:6];
    always_comb begin
        special = op == OP_SPECIAL;
        load    = op[5:3] == 3'b100;
        store   = op[5:3] == 3'b101;
        alu_imm = op[5:3] == 3'b001;
        alu     = alu_imm || (special && fn[5:4] == 2'b10);
        shift   = special && fn[5:3] == 3'b000;
        mulmove = special && fn[5:3] == 3'b010;
        mulexec = special && fn[5:3] == 3'b011;
        jump    = op == OP_J || op == OP_JAL;
        // REGIMM plus BEQ/BNE/BLEZ/BGTZ (opcodes 000100..000111)
        bcond   = op == OP_REGIMM || op[5:2] == 4'b0001;
        branch  = jump || bcond || (special && (fn == FN_JR || fn == FN_JALR));
        cp0     = op == OP_COP0;
        exc     = special && (fn == FN_SYSCALL || fn == FN_BREAK);
        has_imm = load || store || alu_imm || bcond;
        link    = op == OP_JAL || (op == OP_REGIMM && (rt == RT_BLTZAL || rt == RT_BGEZAL));
        rr1     = (jump || exc) ? 5'd0 : rs;
        rr2     = (has_imm || jump) ? 5'd0 : rt;
        rw      = link ? REG_RA : (branch || store) ? 5'd0 : (load || alu_imm) ? rt : rd;
        cls                   = '0;
        cls[CLS_LOAD]         = load;
        cls[CLS_STORE]        = store;
        cls[CLS_ALU]          = alu;
        cls[CLS_SHIFT]        = shift;
        cls[CLS_MULMOVE]      = mulmove;
        cls[CLS_MULEXEC]      = mulexec;
        cls[CLS_BRANCH]       = branch;
        cls[CLS_CP0]          = cp0;
        cls[CLS_EXC]          = exc;
        cls[CLS_HAS_IMM]      = has_imm;
        cls[CLS_COULD_BRANCH] = branch || exc;
        cls[CLS_NOP]          = (alu || shift) && rw == 5'd0;
    end
endmodule

// File: rtl/cpu_decode_queue.sv
// cpu_decode_queue: decode buffer between fetch and issue, classifies at enqueue and presents the oldest ISSUE_W entries
// Ports: clk, rst (sync, active-high), flush; fetch side in_valid/in_ready/in_inst/in_pc;
//        issue side out_valid/out_inst/out_pc/out_cls/out_rr1/out_rr2/out_rw/out_ds per slot, deq_cnt; count occupancy.
// Params: DEPTH (power of two, >= ISSUE_W, >= 2), ISSUE_W (1..4), PC_W (<= 32).
// Option: CPU_DECODE_NOP_DROP_EN consumes nops outside delay slots without storing them.
module cpu_decode_queue import cpu_decode_pkg::*; #(
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2,
    parameter int PC_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_inst,
    input  logic [PC_W-1:0]              in_pc,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [ISSUE_W*32-1:0]        out_inst,
    output logic [ISSUE_W*PC_W-1:0]      out_pc,
    output logic [ISSUE_W*CLS_W-1:0]     out_cls,
    output logic [ISSUE_W*5-1:0]         out_rr1,
    output logic [ISSUE_W*5-1:0]         out_rr2,
    output logic [ISSUE_W*5-1:0]         out_rw,
    output logic [ISSUE_W-1:0]           out_ds,
    input  logic [$clog2(ISSUE_W+1)-1:0] deq_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);
    entry_t           mem [DEPTH];
    logic [AW-1:0]    head, tail;
    logic             ds_pend, enq, wr;
    logic [NW-1:0]    deq;
    logic [CLS_W-1:0] cls;
    logic [4:0]       rr1, rr2, rw;
    cpu_inst_classify u_classify (
        .inst (in_inst),
        .cls  (cls),
        .rr1  (rr1),
        .rr2  (rr2),
        .rw   (rw)
    );
    assign in_ready = count < NW'(DEPTH);
    always_comb begin
        enq = in_valid && in_ready && !flush;
`ifdef CPU_DECODE_NOP_DROP_EN
        wr  = enq && !(cls[CLS_NOP] && !ds_pend);
`else
        wr  = enq;
`endif
        deq = (NW'(deq_cnt) > count) ? count : NW'(deq_cnt);
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ds_pend <= 1'b0;
        end else begin
            if (wr) begin
                mem[tail] <= '{in_inst, 32'(in_pc), cls, rr1, rr2, rw, ds_pend};
                tail      <= tail + AW'(1);
                ds_pend   <= cls[CLS_BRANCH];
            end
            head  <= head + AW'(deq);
            count <= count + NW'(wr) - deq;
        end
    end
    always_ff @(posedge clk)
        if (!rst && !flush)
            assert (NW'(deq_cnt) <= count)
            else $warning("deq_cnt %0d above count %0d, clamped", deq_cnt, count);
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
        entry_t e;
        assign e                          = (NW'(i) < count) ? mem[head + AW'(i)] : '0;
        assign out_valid[i]               = NW'(i) < count;
        assign out_inst[i*32 +: 32]       = e.inst;
        assign out_pc[i*PC_W +: PC_W]     = e.pc[PC_W-1:0];
        assign out_cls[i*CLS_W +: CLS_W]  = e.cls;
        assign out_rr1[i*5 +: 5]          = e.rr1;
        assign out_rr2[i*5 +: 5]          = e.rr2;
        assign out_rw[i*5 +: 5]           = e.rw;
        assign out_ds[i]                  = e.ds;
    end
endmodule

// File: tb/tb_cpu_decode_queue.sv
// tb_cpu_decode_queue: table-driven, scoreboarded bench for cpu_decode_queue
module tb_cpu_decode_queue;
    import cpu_decode_pkg::*;
    localparam int DEPTH = 8;
    localparam int IW    = 2;
`ifdef CPU_DECODE_NOP_DROP_EN
    localparam bit NOP_DROP = 1'b1;
`else
    localparam bit NOP_DROP = 1'b0;
`endif
    logic                clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic [31:0]         in_inst = '0, in_pc = '0;
    logic [1:0]          deq_cnt = '0;
    logic                in_ready;
    logic [IW-1:0]       out_valid, out_ds;
    logic [IW*32-1:0]    out_inst, out_pc;
    logic [IW*CLS_W-1:0] out_cls;
    logic [IW*5-1:0]     out_rr1, out_rr2, out_rw;
    logic [3:0]          count;
    always #5 clk = ~clk;
    cpu_decode_queue #(.DEPTH(DEPTH), .ISSUE_W(IW), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_inst(out_inst),
        .out_pc(out_pc), .out_cls(out_cls), .out_rr1(out_rr1), .out_rr2(out_rr2),
        .out_rw(out_rw), .out_ds(out_ds), .deq_cnt(deq_cnt), .count(count)
    );
    typedef struct {
        logic [31:0]      inst;
        logic [CLS_W-1:0] cls;
        logic [4:0]       rr1, rr2, rw;
    } vec_t;
    typedef struct packed {
        logic [31:0]      inst, pc;
        logic [CLS_W-1:0] cls;
        logic [4:0]       rr1, rr2, rw;
        logic             ds;
    } exp_t;
    vec_t        vt [17];
    exp_t        sb [$];
    logic        m_ds = 1'b0;
    logic [31:0] pc_ctr = 32'h1000;
    int          n_vec = 0, n_err = 0;
    function automatic logic [CLS_W-1:0] bt(input int i);
        bt = '0;
        bt[i] = 1'b1;
    endfunction
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    function automatic exp_t slot(input int j);
        slot = '{out_inst[j*32 +: 32], out_pc[j*32 +: 32], out_cls[j*CLS_W +: CLS_W],
                 out_rr1[j*5 +: 5], out_rr2[j*5 +: 5], out_rw[j*5 +: 5], out_ds[j]};
    endfunction
    task automatic cyc(input bit v, input int k, input int dq, input bit fl);
        int   n;
        bit   drop;
        exp_t e;
        n        = sb.size();
        in_valid = v;
        in_inst  = vt[k].inst;
        in_pc    = pc_ctr;
        deq_cnt  = 2'(dq);
        flush    = fl;
        chk("count", count, n);
        chk("in_ready", in_ready, n < DEPTH);
        chk("out_valid", out_valid, n >= 2 ? 2'b11 : n == 1 ? 2'b01 : 2'b00);
        if (fl) begin
            sb.delete();
            m_ds = 1'b0;
        end else begin
            for (int j = 0; j < dq && j < n; j++) chk($sformatf("slot%0d", j), slot(j), sb.pop_front());
            if (v && n < DEPTH) begin
                drop = NOP_DROP && vt[k].cls[CLS_NOP] && !m_ds;
                if (!drop) begin
                    e = '{vt[k].inst, pc_ctr, vt[k].cls, vt[k].rr1, vt[k].rr2, vt[k].rw, m_ds};
                    sb.push_back(e);
                    m_ds = vt[k].cls[CLS_BRANCH];
                end
            end
        end
        @(posedge clk);
        #1;
        pc_ctr   += 4;
        in_valid = 1'b0;
        deq_cnt  = '0;
        flush    = 1'b0;
    endtask
    task automatic drain();
        for (int t = 0; t < DEPTH && sb.size() > 0; t++) cyc(0, 0, sb.size() >= 2 ? 2 : sb.size(), 0);
    endtask
    initial begin
        vt[0]  = '{32'h00221821, bt(CLS_ALU),                                     5'd1,  5'd2,  5'd3};
        vt[1]  = '{32'h10220004, bt(CLS_BRANCH) | bt(CLS_HAS_IMM) | bt(CLS_COULD_BRANCH), 5'd1, 5'd0, 5'd0};
        vt[2]  = '{32'h24050007, bt(CLS_ALU) | bt(CLS_HAS_IMM),                   5'd0,  5'd0,  5'd5};
        vt[3]  = '{32'h8CC40008, bt(CLS_LOAD) | bt(CLS_HAS_IMM),                  5'd6,  5'd0,  5'd4};
        vt[4]  = '{32'hAD07000C, bt(CLS_STORE) | bt(CLS_HAS_IMM),                 5'd8,  5'd0,  5'd0};
        vt[5]  = '{32'h000A48C0, bt(CLS_SHIFT),                                   5'd0,  5'd10, 5'd9};
        vt[6]  = '{32'h00005810, bt(CLS_MULMOVE),                                 5'd0,  5'd0,  5'd11};
        vt[7]  = '{32'h018D0018, bt(CLS_MULEXEC),                                 5'd12, 5'd13, 5'd0};
        vt[8]  = '{32'h0C000010, bt(CLS_BRANCH) | bt(CLS_COULD_BRANCH),           5'd0,  5'd0,  5'd31};
        vt[9]  = '{32'h08000020, bt(CLS_BRANCH) | bt(CLS_COULD_BRANCH),           5'd0,  5'd0,  5'd0};
        vt[10] = '{32'h03E00008, bt(CLS_BRANCH) | bt(CLS_COULD_BRANCH),           5'd31, 5'd0,  5'd0};
        vt[11] = '{32'h04510004, bt(CLS_BRANCH) | bt(CLS_HAS_IMM) | bt(CLS_COULD_BRANCH), 5'd2, 5'd0, 5'd31};
        vt[12] = '{32'h0000000C, bt(CLS_EXC) | bt(CLS_COULD_BRANCH),              5'd0,  5'd0,  5'd0};
        vt[13] = '{32'h40846000, bt(CLS_CP0),                                     5'd4,  5'd4,  5'd12};
        vt[14] = '{32'h00000000, bt(CLS_SHIFT) | bt(CLS_NOP),                     5'd0,  5'd0,  5'd0};
        vt[15] = '{32'h24200001, bt(CLS_ALU) | bt(CLS_HAS_IMM) | bt(CLS_NOP),     5'd1,  5'd0,  5'd0};
        vt[16] = '{32'h3C021234, bt(CLS_ALU) | bt(CLS_HAS_IMM),                   5'd0,  5'd0,  5'd2};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_data", {out_inst, out_pc, out_cls, out_rr1, out_rr2, out_rw, out_ds}, 0);
        cyc(1, 0, 0, 0);
        chk("addu_valid", out_valid, 2'b01);
        chk("addu_rr1", out_rr1[4:0], 1);
        chk("addu_rr2", out_rr2[4:0], 2);
        chk("addu_rw", out_rw[4:0], 3);
        chk("addu_alu", out_cls[CLS_ALU], 1);
        chk("addu_ds", out_ds[0], 0);
        chk("empty_slot1_zero", {out_inst[63:32], out_pc[63:32], out_cls[2*CLS_W-1:CLS_W], out_rw[9:5], out_ds[1]}, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 2, 0, 0);
        chk("beq_branch", out_cls[CLS_BRANCH], 1);
        chk("beq_rw", out_rw[4:0], 0);
        chk("beq_rr2", out_rr2[4:0], 0);
        chk("addiu_ds", out_ds[1], 1);
        chk("addiu_rw", out_rw[9:5], 5);
        chk("addiu_imm", out_cls[CLS_W+CLS_HAS_IMM], 1);
        cyc(0, 0, 2, 0);
        for (int k = 0; k < 17; k++) cyc(1, k, sb.size() > 0 ? 1 : 0, 0);
        drain();
        repeat (300) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 16),
                         $urandom_range(0, sb.size() < 2 ? sb.size() : 2), 0);
        drain();
        for (int k = 0; k < DEPTH; k++) cyc(1, k, 0, 0);
        chk("full_count", count, 8);
        chk("full_ready", in_ready, 0);
        cyc(1, 3, 2, 0);
        chk("full_deq_count", count, 6);
        chk("full_deq_ready", in_ready, 1);
        cyc(1, 4, 0, 0);
        drain();
        cyc(1, 8, 0, 0);
        cyc(1, 0, 1, 1);
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        cyc(1, 0, 0, 0);
        chk("flush_ds", out_ds[0], 0);
        drain();
        cyc(1, 14, 0, 0);
        chk("nop_count", count, NOP_DROP ? 0 : 1);
        cyc(1, 9, 0, 0);
        cyc(1, 14, 0, 0);
        chk("nop_ds_count", count, NOP_DROP ? 2 : 3);
        chk("nop_slot1_ds", {out_inst[63:32], out_ds[1]}, NOP_DROP ? 33'h0_0000_0001 : {vt[9].inst, 1'b0});
        drain();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 2, 0);
        chk("clamp_count", count, 0);
        chk("clamp_valid", out_valid, 0);
        cyc(1, 2, 0, 0);
        chk("clamp_recover", count, 1);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
